// File: rtl/ub_fifo_bridge_if.sv
// Handshake bundle between ub_fifo_bridge and its host FIFOs / unified buffer.
// The master modport is the bridge itself; the slave modport is its environment.
interface ub_fifo_bridge_if #(
  parameter int unsigned FIFO_DATA_WIDTH = 8,
  parameter int unsigned ADDRESS_SIZE    = 10
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_dir;
  logic [ADDRESS_SIZE-1:0]    cmd_base_addr;
  logic [ADDRESS_SIZE:0]      cmd_len;
  logic                       busy;
  logic                       done;
  logic                       rx_empty;
  logic [FIFO_DATA_WIDTH-1:0] rx_data;
  logic                       rx_rd_en;
  logic                       tx_full;
  logic                       tx_wr_en;
  logic [FIFO_DATA_WIDTH-1:0] tx_data;
  logic                       ub_we;
  logic                       ub_re;
  logic                       ub_fifo_en;
  logic                       ub_section;
  logic [ADDRESS_SIZE-1:0]    ub_address;
  logic [FIFO_DATA_WIDTH-1:0] ub_fifo_in;
  logic [FIFO_DATA_WIDTH-1:0] ub_fifo_out;

  modport master (
    input  cmd_valid, cmd_dir, cmd_base_addr, cmd_len, rx_empty, rx_data, tx_full, ub_fifo_out,
    output cmd_ready, busy, done, rx_rd_en, tx_wr_en, tx_data, ub_we, ub_re, ub_fifo_en,
           ub_section, ub_address, ub_fifo_in
  );

  modport slave (
    output cmd_valid, cmd_dir, cmd_base_addr, cmd_len, rx_empty, rx_data, tx_full, ub_fifo_out,
    input  cmd_ready, busy, done, rx_rd_en, tx_wr_en, tx_data, ub_we, ub_re, ub_fifo_en,
           ub_section, ub_address, ub_fifo_in
  );
endinterface

// File: rtl/ub_fifo_bridge.sv
// Byte mover between the host RX/TX FIFOs and the unified buffer FIFO port.
// LOAD packs RX bytes low-first into 16-bit words; DRAIN unpacks words low-first into TX.
module ub_fifo_bridge #(
  parameter int unsigned BUFFER_SIZE      = 1024,
  parameter int unsigned FIFO_DATA_WIDTH  = 8,
  parameter int unsigned BUFFER_WORD_SIZE = 16,
  parameter int unsigned ADDRESS_SIZE     = $clog2(BUFFER_SIZE)
) (
  input logic             clk,
  input logic             rst_n,
  ub_fifo_bridge_if.master bus_io
);

  if (BUFFER_WORD_SIZE != 2 * FIFO_DATA_WIDTH) begin : gen_bad_cfg
    $error("BUFFER_WORD_SIZE must equal 2*FIFO_DATA_WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StLd, StDrReq, StDrPush} state_e;

  localparam logic [ADDRESS_SIZE-1:0] AddrOne = 1;
  localparam logic [ADDRESS_SIZE:0]   RemOne  = 1;
  localparam logic [ADDRESS_SIZE:0]   RemZero = '0;

  state_e                  state_q, state_d;
  logic                    done_q, done_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [ADDRESS_SIZE:0]   rem_q, rem_d;
  logic                    sec_q, sec_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      sec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sec_q   <= sec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    rem_d   = rem_q;
    sec_d   = sec_q;

    bus_io.cmd_ready  = (state_q == StIdle);
    bus_io.busy       = (state_q != StIdle);
    bus_io.done       = done_q;
    bus_io.rx_rd_en   = 1'b0;
    bus_io.tx_wr_en   = 1'b0;
    bus_io.tx_data    = bus_io.ub_fifo_out;
    bus_io.ub_we      = 1'b0;
    bus_io.ub_re      = 1'b0;
    bus_io.ub_fifo_en = 1'b0;
    bus_io.ub_section = sec_q;
    bus_io.ub_address = addr_q;
    bus_io.ub_fifo_in = bus_io.rx_data;

    unique case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          addr_d = bus_io.cmd_base_addr;
          rem_d  = bus_io.cmd_len;
          sec_d  = 1'b0;
          if (bus_io.cmd_len == RemZero) begin
            done_d = 1'b1;
          end else begin
            state_d = bus_io.cmd_dir ? StDrReq : StLd;
          end
        end
      end
      StLd: begin
        if (!bus_io.rx_empty) begin
          bus_io.rx_rd_en   = 1'b1;
          bus_io.ub_we      = 1'b1;
          bus_io.ub_fifo_en = 1'b1;
          sec_d             = ~sec_q;
          // A word completes on its high byte.
          if (sec_q) begin
            addr_d = addr_q + AddrOne;
            rem_d  = rem_q - RemOne;
            if (rem_q == RemOne) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      end
      StDrReq: begin
        bus_io.ub_re      = 1'b1;
        bus_io.ub_fifo_en = 1'b1;
        state_d           = StDrPush;
      end
      StDrPush: begin
        // ub_fifo_out holds its value here since no new read is issued while stalled.
        if (!bus_io.tx_full) begin
          bus_io.tx_wr_en = 1'b1;
          sec_d           = ~sec_q;
          state_d         = StDrReq;
          if (sec_q) begin
            addr_d = addr_q + AddrOne;
            rem_d  = rem_q - RemOne;
            if (rem_q == RemOne) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ub_fifo_bridge.sv
// Directed bench for ub_fifo_bridge with RX/TX/buffer models and a queue-based scoreboard.
module tb_ub_fifo_bridge;

  typedef struct packed {
    logic [9:0] a;
    logic       s;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  ub_fifo_bridge_if #(.FIFO_DATA_WIDTH(8), .ADDRESS_SIZE(10)) bus_if ();

  ub_fifo_bridge #(.BUFFER_SIZE(1024)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_if)
  );

  always #5 clk = ~clk;

  // Environment models
  logic [15:0] mem [1024];
  logic [7:0]  rx_buf [64];
  int          rx_wr = 0;
  int          rx_rd = 0;
  logic        starve_en;
  logic        starve = 1'b0;
  logic [7:0]  fo_q = 8'h00;

  assign bus_if.rx_empty    = (rx_rd == rx_wr) || (starve_en && starve);
  assign bus_if.rx_data     = rx_buf[rx_rd];
  assign bus_if.ub_fifo_out = fo_q;

  always @(posedge clk) begin
    if (bus_if.rx_rd_en) rx_rd <= rx_rd + 1;
    if (bus_if.ub_we && bus_if.ub_fifo_en) begin
      if (bus_if.ub_section) mem[bus_if.ub_address][15:8] <= bus_if.ub_fifo_in;
      else                   mem[bus_if.ub_address][7:0]  <= bus_if.ub_fifo_in;
    end
    if (bus_if.ub_re && bus_if.ub_fifo_en)
      fo_q <= bus_if.ub_section ? mem[bus_if.ub_address][15:8] : mem[bus_if.ub_address][7:0];
    starve <= starve_en ? ~starve : 1'b0;
  end

  // Scoreboard
  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int re_cnt = 0;
  int tx_cnt = 0;
  int strobe_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus_if.ub_we || bus_if.ub_re || bus_if.rx_rd_en || bus_if.tx_wr_en || bus_if.ub_fifo_en)
        strobe_cnt++;
      if (bus_if.ub_re) re_cnt++;
      if (bus_if.done) done_cnt++;
      if (bus_if.ub_we) begin
        chk("wr_strobes", {bus_if.ub_re, bus_if.tx_wr_en, bus_if.rx_rd_en, bus_if.ub_fifo_en,
                           bus_if.rx_empty}, 5'b00110);
        if (exp_wr.size() == 0) chk("wr_unexpected", exp_wr.size(), 1);
        else chk("wr", {bus_if.ub_address, bus_if.ub_section, bus_if.ub_fifo_in}, exp_wr.pop_front());
      end
      if (bus_if.tx_wr_en) begin
        tx_cnt++;
        chk("tx_strobes", {bus_if.tx_full, bus_if.rx_rd_en, bus_if.ub_we}, 3'b000);
        if (exp_tx.size() == 0) chk("tx_unexpected", exp_tx.size(), 1);
        else chk("tx_byte", bus_if.tx_data, exp_tx.pop_front());
      end
    end
  end

  task automatic put_rx(input logic [7:0] b);
    rx_buf[rx_wr] = b;
    rx_wr++;
  endtask

  task automatic exp_w(input logic [9:0] a, input logic s, input logic [7:0] d);
    wr_t e;
    e.a = a; e.s = s; e.d = d;
    exp_wr.push_back(e);
  endtask

  task automatic issue(input logic dir, input logic [9:0] base, input logic [10:0] len);
    bus_if.cmd_dir       = dir;
    bus_if.cmd_base_addr = base;
    bus_if.cmd_len       = len;
    bus_if.cmd_valid     = 1'b1;
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    int start;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == start) chk("done_timeout", done_cnt - start, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, r0, t0, s0;
    rst_n            = 1'b0;
    starve_en        = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_dir   = 1'b0;
    bus_if.cmd_base_addr = '0;
    bus_if.cmd_len   = '0;
    bus_if.tx_full   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus_if.cmd_ready, bus_if.busy, bus_if.done, bus_if.rx_rd_en,
                          bus_if.tx_wr_en, bus_if.ub_we, bus_if.ub_re, bus_if.ub_fifo_en},
        8'b1000_0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LOAD base 0x010 len 2
    put_rx(8'h11); put_rx(8'h22); put_rx(8'h33); put_rx(8'h44);
    exp_w(10'h010, 1'b0, 8'h11); exp_w(10'h010, 1'b1, 8'h22);
    exp_w(10'h011, 1'b0, 8'h33); exp_w(10'h011, 1'b1, 8'h44);
    d0 = done_cnt;
    issue(1'b0, 10'h010, 11'd2);
    wait_done(n);
    chk("ld_cycles", n, 5);
    chk("ld_done_once", done_cnt - d0, 1);
    chk("ld_done_idle", {bus_if.done, bus_if.busy, bus_if.cmd_ready}, 3'b101);
    chk("ld_word0", mem[16], 16'h2211);
    chk("ld_word1", mem[17], 16'h4433);
    chk("ld_wr_left", exp_wr.size(), 0);

    // DRAIN base 0x010 len 2
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
    exp_tx.push_back(8'h33); exp_tx.push_back(8'h44);
    d0 = done_cnt; r0 = re_cnt; t0 = tx_cnt;
    issue(1'b1, 10'h010, 11'd2);
    wait_done(n);
    chk("dr_cycles", n, 9);
    chk("dr_done_once", done_cnt - d0, 1);
    chk("dr_re_count", re_cnt - r0, 4);
    chk("dr_tx_count", tx_cnt - t0, 4);
    chk("dr_tx_left", exp_tx.size(), 0);

    // DRAIN len 1 with TX full for 5 cycles after the first read
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
    r0 = re_cnt; t0 = tx_cnt;
    bus_if.tx_full = 1'b1;
    issue(1'b1, 10'h010, 11'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_no_push", tx_cnt - t0, 0);
    chk("bp_one_re", re_cnt - r0, 1);
    bus_if.tx_full = 1'b0;
    wait_done(n);
    chk("bp_tail_cycles", n, 4);
    chk("bp_re_count", re_cnt - r0, 2);
    chk("bp_tx_count", tx_cnt - t0, 2);
    chk("bp_tx_left", exp_tx.size(), 0);

    // LOAD with RX starvation, wrapping past the top word
    starve_en = 1'b1;
    put_rx(8'ha1); put_rx(8'hb2); put_rx(8'hc3); put_rx(8'hd4);
    exp_w(10'd1023, 1'b0, 8'ha1); exp_w(10'd1023, 1'b1, 8'hb2);
    exp_w(10'd0, 1'b0, 8'hc3);    exp_w(10'd0, 1'b1, 8'hd4);
    d0 = done_cnt;
    issue(1'b0, 10'd1023, 11'd2);
    wait_done(n);
    starve_en = 1'b0;
    chk("wrap_stall_cycles", (n >= 8 && n <= 9), 1);
    chk("wrap_done_once", done_cnt - d0, 1);
    chk("wrap_word_top", mem[1023], 16'hb2a1);
    chk("wrap_word_zero", mem[0], 16'hd4c3);
    chk("wrap_wr_left", exp_wr.size(), 0);

    // Zero-length command
    d0 = done_cnt; s0 = strobe_cnt;
    issue(1'b0, 10'h005, 11'd0);
    wait_done(n);
    chk("len0_latency", n, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("len0_done_once", done_cnt - d0, 1);
    chk("len0_no_strobes", strobe_cnt - s0, 0);

    // Reset in the middle of a LOAD
    put_rx(8'h01); put_rx(8'h02); put_rx(8'h03); put_rx(8'h04); put_rx(8'h05);
    exp_w(10'h020, 1'b0, 8'h01); exp_w(10'h020, 1'b1, 8'h02); exp_w(10'h021, 1'b0, 8'h03);
    d0 = done_cnt;
    issue(1'b0, 10'h020, 11'd2);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus_if.rx_rd_en, bus_if.ub_we, bus_if.ub_re, bus_if.ub_fifo_en,
                            bus_if.tx_wr_en, bus_if.busy, bus_if.done, bus_if.cmd_ready},
        8'b0000_0001);
    chk("rst_mid_writes", exp_wr.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt - d0, 0);
    exp_w(10'h030, 1'b0, 8'h04); exp_w(10'h030, 1'b1, 8'h05);
    issue(1'b0, 10'h030, 11'd1);
    wait_done(n);
    chk("post_rst_cycles", n, 3);
    chk("post_rst_word", mem[48], 16'h0504);
    chk("rst_kept_word", mem[32], 16'h0201);
    chk("rst_kept_byte", mem[33][7:0], 8'h03);
    chk("post_rst_wr_left", exp_wr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
